// File: rtl/bus_arbiter_if.sv
// Bus arbiter interface: bundles the per-requester request/release strobes
// and the arbiter's grant/status outputs.
//   req      requester -> arbiter  per-requester level request
//   done     requester -> arbiter  per-requester release strobe
//   gnt      arbiter -> requester  registered one-hot grant
//   owner    arbiter -> requester  index of current/last owner
//   bus_busy arbiter -> requester  high while a requester owns the bus
//   timeout  arbiter -> requester  one-cycle pulse after a forced release
// Modports: slave = arbiter side, master = requester/controller side.
interface bus_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  done;
    logic [NREQ-1:0]  gnt;
    logic [IDX_W-1:0] owner;
    logic             bus_busy;
    logic             timeout;

    modport slave (
        input  req,
        input  done,
        output gnt,
        output owner,
        output bus_busy,
        output timeout
    );

    modport master (
        output req,
        output done,
        input  gnt,
        input  owner,
        input  bus_busy,
        input  timeout
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared 8-bit internal data bus
// (0 = controller fetch, 1 = register bank, 2 = memory load, 3 = I/O port).
// A dead turnaround cycle is inserted between owners so that two drivers
// never overlap on the bus.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    bus_arbiter_if.slave (req, done in; gnt, owner, bus_busy, timeout out)
//
// Optional feature macro: BUS_TIMEOUT_EN
//   defined   : an owner is forcibly released after MAX_HOLD cycles and
//               timeout pulses during the following turnaround cycle
//   undefined : no hold counter, an owner keeps the bus until it releases,
//               timeout is tied low
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no owner, gnt = 0, grant on the next edge if any req is set
// OWN   | gnt[owner] held, bus_busy = 1, wait for done/req drop (or timeout)
// TURN  | single dead cycle between owners, gnt = 0
module bus_arbiter #(
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic           clk,
    input  logic           reset,
    bus_arbiter_if.slave   bus
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("bus_arbiter: NREQ must be in 2..8");
    end
    if ((2 ** CNT_W) <= MAX_HOLD || MAX_HOLD < 1) begin : g_bad_hold
        $error("bus_arbiter: need 1 <= MAX_HOLD < 2**CNT_W");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_TURN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic             sel_valid;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W:0]   cand;
    logic [IDX_W-1:0] owner_next;
    logic             user_rel;
    logic             hold_expired;

    // Search req starting at ptr with wrap; the extra cand bit keeps
    // ptr + i from overflowing before the modulo correction.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr_q} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NREQ)) begin
                cand = cand - (IDX_W+1)'(NREQ);
            end
            if (!sel_valid && bus.req[cand[IDX_W-1:0]]) begin
                sel_valid = 1'b1;
                sel_idx   = cand[IDX_W-1:0];
            end
        end
    end

    assign owner_next = (owner_q == IDX_W'(NREQ - 1)) ? '0 : owner_q + 1'b1;

    // Only the owner's own strobes count; everyone else is ignored.
    assign user_rel = bus.done[owner_q] | ~bus.req[owner_q];

`ifdef BUS_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             timeout_q, timeout_d;

    // hold_cnt is 0 in the first OWN cycle, so comparing against
    // MAX_HOLD-1 gives exactly MAX_HOLD cycles of ownership.
    assign hold_expired = (state_q == ST_OWN) &&
                          (hold_cnt_q == CNT_W'(MAX_HOLD - 1));

    always_comb begin
        hold_cnt_d = '0;
        timeout_d  = 1'b0;
        if (state_q == ST_OWN) begin
            if (user_rel || hold_expired) begin
                hold_cnt_d = '0;
                timeout_d  = hold_expired & ~user_rel;
            end else begin
                hold_cnt_d = (hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign hold_expired = 1'b0;
    assign bus.timeout  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            ST_IDLE, ST_TURN: begin
                gnt_d = '0;
                if (sel_valid) begin
                    gnt_d   = NREQ'(1) << sel_idx;
                    owner_d = sel_idx;
                    state_d = ST_OWN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWN: begin
                if (user_rel || hold_expired) begin
                    gnt_d   = '0;
                    ptr_d   = owner_next;
                    state_d = ST_TURN;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.owner    = owner_q;
    assign bus.bus_busy = (state_q == ST_OWN);
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter with a per-cycle reference model.
module tb_bus_arbiter;
    localparam int NREQ     = 4;
    localparam int MAX_HOLD = 4;
`ifdef BUS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bus_arbiter_if #(.NREQ(NREQ)) bif ();

    bus_arbiter #(
        .NREQ    (NREQ),
        .MAX_HOLD(MAX_HOLD),
        .CNT_W   (5)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bif)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the bus (-1 = nobody), last owner shown on
    // the owner output, rotating start point, cycles held, timeout pulse.
    int m_owner;
    int m_last;
    int m_ptr;
    int m_hold;
    bit m_to;
    bit m_normal;
    bit m_forced;
    int m_pick;

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int i = 0; i < NREQ; i++) begin
            if (r[(p + i) % NREQ]) return (p + i) % NREQ;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_owner = -1;
            m_last  = 0;
            m_ptr   = 0;
            m_hold  = 0;
            m_to    = 1'b0;
        end else begin
            m_to = 1'b0;
            if (m_owner >= 0) begin
                m_normal = bif.done[m_owner] || !bif.req[m_owner];
                m_hold   = m_hold + 1;
                m_forced = TO_EN && (m_hold >= MAX_HOLD);
                if (m_normal || m_forced) begin
                    m_to    = m_forced && !m_normal;
                    m_ptr   = (m_owner + 1) % NREQ;
                    m_owner = -1;
                end
            end else begin
                m_pick = rr_pick(bif.req, m_ptr);
                if (m_pick >= 0) begin
                    m_owner = m_pick;
                    m_last  = m_pick;
                    m_hold  = 0;
                end
            end
        end
    end

    logic [NREQ-1:0] exp_gnt;
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            exp_gnt = (m_owner >= 0) ? NREQ'(1) << m_owner : '0;
            chk("cmp_gnt", 32'(bif.gnt), 32'(exp_gnt));
            chk("cmp_owner", 32'(bif.owner), m_last);
            chk("cmp_busy", 32'(bif.bus_busy), 32'(m_owner >= 0));
            chk("cmp_timeout", 32'(bif.timeout), 32'(m_to));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    int exp_order [5] = '{0, 1, 2, 3, 0};
    int waited;

    initial begin
        reset    = 1'b1;
        bif.req  = '0;
        bif.done = '0;
        #1 reset = 1'b0;
        #10;
        chk("rst_gnt", 32'(bif.gnt), 32'h0);
        chk("rst_owner", 32'(bif.owner), 32'h0);
        chk("rst_busy", 32'(bif.bus_busy), 32'h0);
        chk("rst_timeout", 32'(bif.timeout), 32'h0);
        @(posedge clk);
        #2 reset = 1'b1;

        // Round robin with all four requesting
        bif.req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            waited = 0;
            while (bif.gnt == '0 && waited < 10) begin
                tick(1);
                waited++;
            end
            chk("rr_grant_seen", 32'(bif.gnt != '0), 32'h1);
            chk("rr_order", 32'(bif.gnt), 32'(1 << exp_order[g]));
            if (g > 0) chk("rr_gap", waited, 1);
            tick(1);
            bif.done = NREQ'(1) << exp_order[g];
            tick(1);
            bif.done = '0;
            if (g == 4) bif.req = '0;
            chk("rr_release", 32'(bif.gnt), 32'h0);
        end
        tick(2);

        // Single requester
        bif.req = 4'b0100;
        tick(1);
        chk("single_gnt", 32'(bif.gnt), 32'h4);
        chk("single_owner", 32'(bif.owner), 32'h2);
        chk("single_busy", 32'(bif.bus_busy), 32'h1);
        tick(3);
        bif.done = 4'b0100;
        bif.req  = '0;
        tick(1);
        bif.done = '0;
        chk("single_turn_gnt", 32'(bif.gnt), 32'h0);
        chk("single_turn_busy", 32'(bif.bus_busy), 32'h0);
        chk("single_turn_owner", 32'(bif.owner), 32'h2);
        tick(1);
        chk("single_idle_gnt", 32'(bif.gnt), 32'h0);

        // Pointer skip: after owner 1 releases, index 3 wins over index 0
        bif.req = 4'b0010;
        tick(1);
        chk("skip_own1", 32'(bif.gnt), 32'h2);
        bif.req = 4'b1011;
        tick(1);
        chk("skip_no_preempt", 32'(bif.gnt), 32'h2);
        bif.done = 4'b0010;
        bif.req  = 4'b1001;
        tick(1);
        bif.done = '0;
        chk("skip_turn", 32'(bif.gnt), 32'h0);
        tick(1);
        chk("skip_next_gnt", 32'(bif.gnt), 32'h8);
        chk("skip_next_owner", 32'(bif.owner), 32'h3);
        bif.req = '0;
        tick(1);
        chk("skip_release", 32'(bif.gnt), 32'h0);
        tick(1);

        // Non-owner done is ignored; owner's req drop releases
        bif.req = 4'b0001;
        tick(1);
        chk("nod_own0", 32'(bif.gnt), 32'h1);
        bif.done = 4'b0010;
        tick(1);
        chk("nod_ignored", 32'(bif.gnt), 32'h1);
        bif.done = '0;
        bif.req  = '0;
        tick(1);
        chk("nod_turn_gnt", 32'(bif.gnt), 32'h0);
        chk("nod_turn_busy", 32'(bif.bus_busy), 32'h0);
        tick(1);

        // Asynchronous reset in the middle of an ownership
        bif.req = 4'b0010;
        tick(1);
        chk("arst_pre_gnt", 32'(bif.gnt), 32'h2);
        #1 reset = 1'b0;
        #1;
        chk("arst_gnt", 32'(bif.gnt), 32'h0);
        chk("arst_busy", 32'(bif.bus_busy), 32'h0);
        chk("arst_owner", 32'(bif.owner), 32'h0);
        bif.req = 4'b0100;
        @(posedge clk);
        #2 reset = 1'b1;
        tick(1);
        chk("arst_regrant_gnt", 32'(bif.gnt), 32'h4);
        chk("arst_regrant_owner", 32'(bif.owner), 32'h2);
        bif.req = '0;
        tick(1);
        chk("arst_release", 32'(bif.gnt), 32'h0);
        tick(1);

        // Hold timeout (or indefinite hold without the feature)
        bif.req = 4'b0010;
        tick(1);
`ifdef BUS_TIMEOUT_EN
        for (int k = 0; k < MAX_HOLD; k++) begin
            chk("to_hold_gnt", 32'(bif.gnt), 32'h2);
            chk("to_hold_flag", 32'(bif.timeout), 32'h0);
            tick(1);
        end
        chk("to_turn_gnt", 32'(bif.gnt), 32'h0);
        chk("to_turn_flag", 32'(bif.timeout), 32'h1);
        tick(1);
        chk("to_regrant_gnt", 32'(bif.gnt), 32'h2);
        chk("to_regrant_flag", 32'(bif.timeout), 32'h0);
`else
        tick(55);
        chk("hold_gnt", 32'(bif.gnt), 32'h2);
        chk("hold_busy", 32'(bif.bus_busy), 32'h1);
        chk("hold_timeout", 32'(bif.timeout), 32'h0);
`endif
        bif.req = '0;
        tick(3);
        chk("end_idle_gnt", 32'(bif.gnt), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
